// File: rtl/decode_lane_arbiter.sv
// -----------------------------------------------------------------------------
// decode_lane_arbiter
//
// Round-robin arbiter that moves one Aurora word at a time from four receive
// lanes into a single packet decoder.  A word is granted only while the
// decoder reports ready.  The chosen lane is popped once and the decoder
// receives a one-cycle start.  The arbiter then waits for decode_done, or
// abandons the word after TIMEOUT_CYCLES cycles and raises a sticky
// timeout_err.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   lane_valid[3:0]   lane i holds a word
//   lane_data         lane i word on bits [i*W +: W]
//   lane_pop[3:0]     one-hot, one-cycle pulse consuming the granted word
//   ready_decode_pkt  decoder can accept a word
//   decode_done       decoder finished the current word (pulse)
//   start_decode_pkt  one-cycle request to the decoder
//   data_recv         word presented to the decoder
//   grant_lane        index of the lane being served
//   busy              high whenever the FSM is not in IDLE
//   timeout_err       sticky timeout flag, cleared only by reset
//   words_fwd         saturating count of completed words
// -----------------------------------------------------------------------------
module decode_lane_arbiter #(
    parameter int AURORA_DATA_WIDTH = 256,
    parameter int NUM_LANES         = 4,
    parameter int TIMEOUT_CYCLES    = 15
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_LANES-1:0]                   lane_valid,
    input  logic [NUM_LANES*AURORA_DATA_WIDTH-1:0] lane_data,
    output logic [NUM_LANES-1:0]                   lane_pop,
    input  logic                                   ready_decode_pkt,
    input  logic                                   decode_done,
    output logic                                   start_decode_pkt,
    output logic [AURORA_DATA_WIDTH-1:0]           data_recv,
    output logic [1:0]                             grant_lane,
    output logic                                   busy,
    output logic                                   timeout_err,
    output logic [15:0]                            words_fwd
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    // Counter value seen during the last permitted WAIT_DONE cycle.
    localparam logic [3:0] TMO_LAST   = 4'(TIMEOUT_CYCLES - 1);

    // First valid lane at or after ptr, modulo 4.  Only meaningful when at
    // least one lane is valid.  The loop walks the offsets from farthest to
    // nearest, so the nearest valid lane is the last one assigned.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                           input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (valid[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    logic [1:0]                   state_q, state_d;
    logic [1:0]                   rr_ptr_q, rr_ptr_d;
    logic [3:0]                   tmo_cnt_q, tmo_cnt_d;
    logic [NUM_LANES-1:0]         lane_pop_q, lane_pop_d;
    logic                         start_q, start_d;
    logic [AURORA_DATA_WIDTH-1:0] data_recv_q, data_recv_d;
    logic [1:0]                   grant_q, grant_d;
    logic                         busy_q, busy_d;
    logic                         timeout_err_q, timeout_err_d;
    logic [15:0]                  words_fwd_q, words_fwd_d;

    logic [AURORA_DATA_WIDTH-1:0] lane_word_s [NUM_LANES];
    logic [1:0]                   pick_s;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_word
        assign lane_word_s[g] = lane_data[g*AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH];
    end

    assign pick_s = rr_pick(lane_valid, rr_ptr_q);

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tmo_cnt_d     = tmo_cnt_q;
        lane_pop_d    = {NUM_LANES{1'b0}};
        start_d       = 1'b0;
        data_recv_d   = data_recv_q;
        grant_d       = grant_q;
        timeout_err_d = timeout_err_q;
        words_fwd_d   = words_fwd_q;

        case (state_q)
            ST_IDLE: begin
                if ((|lane_valid) && ready_decode_pkt) begin
                    grant_d     = pick_s;
                    data_recv_d = lane_word_s[pick_s];
                    // Pop and start become visible together in the ISSUE cycle.
                    lane_pop_d  = 4'b0001 << pick_s;
                    start_d     = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = 4'd0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving in the final permitted cycle still counts.
                if (decode_done) begin
                    if (words_fwd_q != 16'hFFFF) begin
                        words_fwd_d = words_fwd_q + 16'd1;
                    end else begin
                        words_fwd_d = words_fwd_q;
                    end
                    rr_ptr_d = grant_q + 2'd1;
                    state_d  = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = grant_q + 2'd1;
                    state_d       = ST_RECOVER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= 2'd0;
            tmo_cnt_q     <= 4'd0;
            lane_pop_q    <= {NUM_LANES{1'b0}};
            start_q       <= 1'b0;
            data_recv_q   <= {AURORA_DATA_WIDTH{1'b0}};
            grant_q       <= 2'd0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            words_fwd_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            lane_pop_q    <= lane_pop_d;
            start_q       <= start_d;
            data_recv_q   <= data_recv_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            words_fwd_q   <= words_fwd_d;
        end
    end

    assign lane_pop         = lane_pop_q;
    assign start_decode_pkt = start_q;
    assign data_recv        = data_recv_q;
    assign grant_lane       = grant_q;
    assign busy             = busy_q;
    assign timeout_err      = timeout_err_q;
    assign words_fwd        = words_fwd_q;

endmodule

// File: tb/tb_decode_lane_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for decode_lane_arbiter.
// The driver issues one transaction at a time and pushes the expected grant
// into a scoreboard queue.  The expectation comes from a lane-level reference
// model made of a pointer, a word count and an error flag.  A separate monitor
// pops the queue each time the DUT raises start_decode_pkt.
// -----------------------------------------------------------------------------
module tb_decode_lane_arbiter;

    localparam int W = 256;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     lane_valid;
    logic [4*W-1:0] lane_data;
    logic [3:0]     lane_pop;
    logic           ready_decode_pkt;
    logic           decode_done;
    logic           start_decode_pkt;
    logic [W-1:0]   data_recv;
    logic [1:0]     grant_lane;
    logic           busy;
    logic           timeout_err;
    logic [15:0]    words_fwd;

    decode_lane_arbiter #(
        .AURORA_DATA_WIDTH (W),
        .NUM_LANES         (4),
        .TIMEOUT_CYCLES    (15)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lane_valid       (lane_valid),
        .lane_data        (lane_data),
        .lane_pop         (lane_pop),
        .ready_decode_pkt (ready_decode_pkt),
        .decode_done      (decode_done),
        .start_decode_pkt (start_decode_pkt),
        .data_recv        (data_recv),
        .grant_lane       (grant_lane),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .words_fwd        (words_fwd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           lane;
        logic [W-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int   m_ptr   = 0;
    int   m_words = 0;
    bit   m_terr  = 1'b0;

    task automatic check(input bit ok, input string name,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int ref_lane(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4*W/32; i++) lane_data[i*32 +: 32] = $urandom;
    endtask

    task automatic check_zero_outputs();
        check(lane_pop == 4'b0,         "rst_lane_pop",    lane_pop, 0);
        check(start_decode_pkt == 1'b0, "rst_start",       start_decode_pkt, 0);
        check(data_recv == '0,          "rst_data_recv",   data_recv, 0);
        check(grant_lane == 2'd0,       "rst_grant_lane",  grant_lane, 0);
        check(busy == 1'b0,             "rst_busy",        busy, 0);
        check(timeout_err == 1'b0,      "rst_timeout_err", timeout_err, 0);
        check(words_fwd == 16'd0,       "rst_words_fwd",   words_fwd, 0);
    endtask

    // Monitor: every start must match the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (start_decode_pkt) begin
            if (sbq.size() == 0) begin
                check(1'b0, "unexpected_start", grant_lane, 0);
            end else begin
                e = sbq.pop_front();
                check(grant_lane == 2'(e.lane), "grant_lane", grant_lane, e.lane);
                check(data_recv == e.data, "data_recv", data_recv, e.data);
                check(lane_pop == (4'b0001 << e.lane), "lane_pop", lane_pop, 4'b0001 << e.lane);
            end
        end else if (lane_pop != 4'b0) begin
            check(1'b0, "pop_without_start", lane_pop, 0);
        end
    end

    // One transaction from IDLE.  delay 1..15 = done in that WAIT_DONE cycle,
    // delay 0 = decoder never answers.
    task automatic do_txn(input logic [3:0] v, input int delay);
        exp_t e;
        int   lane;
        lane_valid = v;
        rand_data();
        lane = ref_lane(v, m_ptr);
        e.lane = lane;
        e.data = lane_data[lane*W +: W];
        sbq.push_back(e);
        ready_decode_pkt = 1'b1;
        step();                               // grant edge
        ready_decode_pkt = 1'b0;
        check(start_decode_pkt == 1'b1, "start_after_grant", start_decode_pkt, 1);
        lane_valid  = 4'($urandom);
        rand_data();
        decode_done = 1'($urandom);           // must be ignored in ISSUE
        step();                               // now in first WAIT_DONE cycle
        decode_done = 1'b0;
        if (delay > 0) begin
            repeat (delay - 1) step();
            decode_done = 1'b1;
            step();
            decode_done = 1'b0;
            m_words = (m_words >= 65535) ? 65535 : m_words + 1;
            m_ptr   = (lane + 1) % 4;
            check(busy == 1'b0, "busy_after_done", busy, 0);
        end else begin
            repeat (14) step();
            check(busy == 1'b1, "busy_wait_15th", busy, 1);
            check(timeout_err == m_terr, "timeout_not_early", timeout_err, m_terr);
            step();
            m_terr = 1'b1;
            m_ptr  = (lane + 1) % 4;
            check(timeout_err == 1'b1, "timeout_err_set", timeout_err, 1);
            check(busy == 1'b1, "busy_recover", busy, 1);
            decode_done = 1'b1;               // must be ignored in RECOVER
            step();
            decode_done = 1'b0;
            check(busy == 1'b0, "busy_after_recover", busy, 0);
        end
        check(words_fwd == 16'(m_words), "words_fwd", words_fwd, m_words);
        check(timeout_err == m_terr, "timeout_err", timeout_err, m_terr);
        check(data_recv == e.data, "data_recv_hold", data_recv, e.data);
        check(grant_lane == 2'(lane), "grant_lane_hold", grant_lane, lane);
        lane_valid = 4'b0;
    endtask

    initial begin
        exp_t e;
        int   lane;
        rst_n = 1'b0;
        lane_valid = 4'b0;
        lane_data = '0;
        ready_decode_pkt = 1'b0;
        decode_done = 1'b0;
        repeat (3) step();
        check_zero_outputs();
        rst_n = 1'b1;
        step();

        // Single lane 2 from reset
        do_txn(4'b0100, 3);
        check(m_ptr == 3, "rr_ptr_after_lane2", m_ptr, 3);

        // Done pulse in IDLE is ignored
        decode_done = 1'b1;
        step();
        decode_done = 1'b0;
        check(words_fwd == 16'(m_words), "idle_done_ignored", words_fwd, m_words);

        // All lanes valid: round robin
        for (int i = 0; i < 5; i++) do_txn(4'b1111, 1);

        // Ready low holds off the grant
        lane_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            check(start_decode_pkt == 1'b0 && lane_pop == 4'b0, "no_grant_without_ready",
                  {start_decode_pkt, lane_pop}, 0);
        end
        do_txn(4'b0001, 2);

        // Timeout, then next grant goes to the following lane
        do_txn(4'b1111, 0);
        do_txn(4'b1111, 15);

        // Randomized transactions
        for (int i = 0; i < 30; i++) begin
            do_txn(4'($urandom_range(1, 15)), ($urandom % 5 == 0) ? 0 : $urandom_range(1, 15));
        end

        // Saturation of words_fwd
        force dut.words_fwd_q = 16'hFFFD;
        step();
        release dut.words_fwd_q;
        m_words = 65533;
        check(words_fwd == 16'hFFFD, "words_preload", words_fwd, 16'hFFFD);
        for (int i = 0; i < 3; i++) do_txn(4'($urandom_range(1, 15)), $urandom_range(1, 15));
        check(words_fwd == 16'hFFFF, "words_saturated", words_fwd, 16'hFFFF);

        // Asynchronous reset in WAIT_DONE
        lane_valid = 4'($urandom_range(1, 15));
        rand_data();
        lane = ref_lane(lane_valid, m_ptr);
        e.lane = lane;
        e.data = lane_data[lane*W +: W];
        sbq.push_back(e);
        ready_decode_pkt = 1'b1;
        step();
        ready_decode_pkt = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs();
        m_ptr = 0; m_words = 0; m_terr = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check(lane_pop == 4'b0, "no_pop_after_reset", lane_pop, 0);
        do_txn(4'($urandom_range(1, 15)), 4);
        do_txn(4'b1010, 1);

        step();
        check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_lane_arbiter.md
DECODE_LANE_ARBITER -- requirements
Module: decode_lane_arbiter

Interface
REQ-001 Parameter AURORA_DATA_WIDTH, 256, width of one Aurora word per lane.
REQ-002 Parameter NUM_LANES, 4, number of receive lanes; fixed at 4, so the lane index is 2 bits.
REQ-003 Parameter TIMEOUT_CYCLES, 15, maximum WAIT_DONE cycles before the transfer is abandoned.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 lane_valid  in  4  bit i high means lane i holds a word.
REQ-007 lane_data  in  4*AURORA_DATA_WIDTH  lane i word on bits [i*256 +: 256].
REQ-008 lane_pop  out  4  one-hot, one-cycle pulse; the word of the granted lane is consumed.
REQ-009 ready_decode_pkt  in  1  the decoder can accept a word.
REQ-010 decode_done  in  1  the decoder finished the current word (pulse).
REQ-011 start_decode_pkt  out  1  one-cycle request to the decoder.
REQ-012 data_recv  out  AURORA_DATA_WIDTH  word presented to the decoder.
REQ-013 grant_lane  out  2  index of the lane being served.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 timeout_err  out  1  sticky flag; cleared only by reset.
REQ-016 words_fwd  out  16  count of completed words; saturates at 16'hFFFF.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT_DONE and RECOVER; all outputs SHALL be registered.
REQ-018 IDLE: when (|lane_valid) and ready_decode_pkt are both high at edge T, the block SHALL select the first valid lane at or after rr_ptr, modulo 4, and latch it into grant_lane.
- At the same edge T it SHALL latch that lane's word into data_recv and go to ISSUE.
REQ-019 ISSUE, cycle T+1: start_decode_pkt=1 and lane_pop[grant_lane]=1 for exactly this one cycle; next state WAIT_DONE.
REQ-020 WAIT_DONE, on decode_done=1:
- words_fwd +1, saturating.
- rr_ptr = grant_lane+1 (wraps 3->0).
- next state IDLE.
REQ-021 WAIT_DONE, when TIMEOUT_CYCLES cycles elapse without decode_done:
- timeout_err=1.
- rr_ptr = grant_lane+1.
- next state RECOVER; words_fwd is unchanged.
REQ-022 RECOVER SHALL last one cycle, then go to IDLE; a decode_done arriving in RECOVER SHALL be ignored.
REQ-023 data_recv and grant_lane SHALL hold stable from ISSUE until the next grant.
REQ-024 The block SHALL NOT issue a request while ready_decode_pkt=0, even if lanes are valid.
REQ-025 When several lanes are valid, lanes SHALL be served round-robin, giving at most 3 intervening grants per lane.
REQ-026 A decode_done pulse arriving in IDLE or ISSUE SHALL be ignored.
REQ-027 The lane_pop pulse SHALL occur exactly once per grant, including grants that later time out.
REQ-028 The timeout counter SHALL clear on entry to WAIT_DONE and count WAIT_DONE cycles only.

Reset
REQ-029 While rst_n=0, the block SHALL force:
- state IDLE, rr_ptr=0, timeout counter=0.
- lane_pop=0, start_decode_pkt=0, data_recv=0, grant_lane=0.
- busy=0, timeout_err=0, words_fwd=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer without a further lane_pop; after release, the block SHALL restart arbitration from lane 0.

Verification
REQ-031 lane_valid=4'b0100, ready=1, done 3 cycles after start -> grant_lane=2, lane_pop=4'b0100 at T+1, start at T+1, words_fwd=1, rr_ptr=3.
REQ-032 lane_valid=4'b1111 held, decoder always acknowledges -> grant order 0,1,2,3,0; each lane is popped once per four grants.
REQ-033 lane_valid=4'b0001, ready_decode_pkt=0 for 10 cycles -> no start and no pop; the grant follows the first cycle with ready=1.
REQ-034 decode_done never asserted -> timeout_err=1 after 15 WAIT_DONE cycles, then RECOVER, then IDLE; words_fwd unchanged; the next grant goes to the following lane.
REQ-035 rst_n low in WAIT_DONE -> all outputs 0 asynchronously; the first grant after release starts searching from lane 0.
REQ-036 words_fwd preloaded near 16'hFFFF by forcing, plus 3 completions -> holds at 16'hFFFF.
